melody_sequencer: RTL and testbench
===================================

// Module: melody_sequencer
// PURPOSE
//  Steps through a song held in an external synchronous ROM and drives the note
//  divider input of the square-wave tone generator (22-bit note_div, toggle on
//  count==note_div) plus a mute flag for its audio amplitude mux.
//  Each ROM entry holds one note code and a duration in beats. The block provides
//  play/stop/pause control, optional looping, and an end-of-song pulse.
//  Sits between the board control logic (buttons/switches) and the tone generator.
// PARAMETERS
//  BEAT_DIV  25_000_000  clk cycles per beat (default = 0.25 s at 100 MHz); must be >= 2
//  ADDR_W    6           ROM address width; song holds up to 2**ADDR_W entries
// PORTS
//  clk       in   1       system clock (100 MHz)
//  rst       in   1       synchronous reset, active-high
//  play      in   1       1-cycle pulse: start from entry 0 (ignored unless IDLE)
//  stop      in   1       1-cycle pulse: abort, return to IDLE
//  pause     in   1       level: freeze playback while high
//  loop_en   in   1       level: restart at entry 0 on end marker instead of stopping
//  rom_addr  out  ADDR_W  ROM read address
//  rom_data  in   8       ROM data, valid 1 cycle after rom_addr; [7:4]=note code, [3:0]=beats
//  note_div  out  22      divisor to the tone generator
//  mute      out  1       1 = tone generator output must be silenced
//  busy      out  1       1 in any state except IDLE
//  song_done out  1       1-cycle pulse when the end marker is reached with loop_en=0
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, rom_addr=0, note_div=22'h3FFFFF, mute=1, busy=0, song_done=0,
//   beat/tick counters=0.
//  Note table (div = round(50e6/f)-1). All codes not listed = rest.
//   0 rest    1 C4=191109   2 D4=170263   3 E4=151684   4 F4=143171
//   5 G4=127550   6 A4=113635   7 B4=101238   8 C5=95556
//   Rest: note_div=22'h3FFFFF, mute=1. Musical note: mute=0.
//  Beats field 0 = end-of-song marker; the note code of that entry is ignored.
//  FSM states: IDLE, FETCH, LOAD, PLAY, PAUSED.
//   IDLE  : mute=1. Goes to FETCH when play=1 and stop=0; ptr=0.
//   FETCH : rom_addr=ptr. Goes to LOAD next cycle.
//   LOAD  : rom_data is sampled.
//           If beats=0 and loop_en=1: ptr=0 and go to FETCH.
//           If beats=0 and loop_en=0: song_done=1 for 1 cycle, ptr=0, mute=1, go to IDLE.
//           Otherwise: register note_div/mute from the table, beat_cnt=beats,
//           tick_cnt=0, go to PLAY. The new note_div/mute are visible the cycle after LOAD.
//   PLAY  : tick_cnt increments each cycle. When tick_cnt reaches BEAT_DIV-1 it wraps
//           to 0 and beat_cnt decrements. When beat_cnt hits 0 at that wrap, ptr
//           increments and the FSM goes to FETCH.
//           Each note therefore lasts beats*BEAT_DIV + 2 cycles (FETCH+LOAD gap);
//           note_div and mute hold their previous values through the gap.
//   PAUSED: entered from PLAY when pause=1. Counters are frozen and mute=1; note_div
//           is held. Returns to PLAY when pause=0, with mute restored to the note's value.
//           pause is ignored in FETCH/LOAD and takes effect on the first PLAY cycle.
//  ptr increment past 2**ADDR_W-1 wraps to 0 (a song with no end marker repeats).
//  stop=1 in any state forces, next cycle: IDLE, ptr=0, mute=1, note_div=22'h3FFFFF.
//   stop takes priority over play, pause and the LOAD decisions.
//  play while busy is ignored. rst asserted mid-song produces exactly the reset values.
//  song_done never asserts when loop_en=1 or on a stop.
// TESTING (BEAT_DIV=4, ADDR_W=4)
//  1 ROM {0x12,0x31,0x00}; play -> note_div=191109 for 10 cycles, then 151684 for 6
//    cycles, then song_done pulse; then IDLE, mute=1, busy=0.
//  2 Same ROM with loop_en=1 -> after entry 1 the FSM refetches entry 0 (rom_addr=0);
//    song_done stays 0; the sequence repeats twice, verified by scoreboard.
//  3 Entry 0 = 0x02 (rest, 2 beats) -> mute=1, note_div=22'h3FFFFF for 10 cycles;
//    code 0xF behaves identically.
//  4 pause held high for 7 cycles mid-note -> mute=1 and tick/beat frozen; the note
//    ends exactly 7 cycles later than without the pause.
//  5 stop and play in the same cycle mid-song -> next cycle IDLE, ptr=0, mute=1;
//    a later play restarts from entry 0.
//  6 Full 16-entry ROM with no 0 beats -> rom_addr wraps 15->0; rst mid-note
//    -> all outputs equal the reset values the next cycle.

Source files
------------

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a song stored in an external synchronous ROM and drives
// the tone generator's note divisor and mute flag, with play/stop/pause/loop control.
module melody_sequencer #(
  parameter int unsigned BEAT_DIV = 25_000_000,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [21:0]       note_div,
  output logic              mute,
  output logic              busy,
  output logic              song_done
);

  localparam int unsigned     TickW    = $clog2(BEAT_DIV);
  localparam logic [TickW-1:0] TickLast = TickW'(BEAT_DIV - 1);
  localparam logic [21:0]     DivRest  = 22'h3FFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StPlay,
    StPaused
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic [3:0]         beat_q, beat_d;
  logic [21:0]        div_q, div_d;
  logic               mute_q, mute_d;
  logic               done_q, done_d;

  // Note code to tone-generator divisor; unlisted codes are rests.
  function automatic logic [21:0] note_lookup(input logic [3:0] code);
    logic [21:0] div;
    case (code)
      4'd1:    div = 22'd191109;
      4'd2:    div = 22'd170263;
      4'd3:    div = 22'd151684;
      4'd4:    div = 22'd143171;
      4'd5:    div = 22'd127550;
      4'd6:    div = 22'd113635;
      4'd7:    div = 22'd101238;
      4'd8:    div = 22'd95556;
      default: div = DivRest;
    endcase
    return div;
  endfunction

  // Next-state logic; stop overrides every other decision.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tick_d  = tick_q;
    beat_d  = beat_q;
    div_d   = div_q;
    mute_d  = mute_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = StIdle;
      ptr_d   = '0;
      div_d   = DivRest;
      mute_d  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (play) begin
            state_d = StFetch;
            ptr_d   = '0;
          end
        end
        StFetch: state_d = StLoad;
        StLoad: begin
          if (rom_data[3:0] == 4'd0) begin
            // End marker: restart or finish the song.
            ptr_d = '0;
            if (loop_en) begin
              state_d = StFetch;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
              mute_d  = 1'b1;
              div_d   = DivRest;
            end
          end else begin
            div_d   = note_lookup(rom_data[7:4]);
            mute_d  = (note_lookup(rom_data[7:4]) == DivRest);
            beat_d  = rom_data[3:0];
            tick_d  = '0;
            state_d = StPlay;
          end
        end
        StPlay, StPaused: begin
          // Counters only advance on cycles where pause is low.
          if (pause) begin
            state_d = StPaused;
          end else begin
            state_d = StPlay;
            if (tick_q == TickLast) begin
              tick_d = '0;
              beat_d = beat_q - 4'd1;
              if (beat_q == 4'd1) begin
                ptr_d   = ptr_q + 1'b1;
                state_d = StFetch;
              end
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      tick_q  <= '0;
      beat_q  <= '0;
      div_q   <= DivRest;
      mute_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tick_q  <= tick_d;
      beat_q  <= beat_d;
      div_q   <= div_d;
      mute_q  <= mute_d;
      done_q  <= done_d;
    end
  end

  // Output mapping; pausing silences the note without losing its mute setting.
  always_comb begin
    rom_addr  = ptr_q;
    note_div  = div_q;
    mute      = mute_q | (state_q == StPaused);
    busy      = (state_q != StIdle);
    song_done = done_q;
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Testbench for melody_sequencer: directed scenarios plus random control traffic,
// checked every cycle against a note-timeline reference model.
module tb_melody_sequencer;

  localparam int unsigned BeatDiv = 4;
  localparam int unsigned AddrW   = 4;
  localparam logic [21:0] DivRest = 22'h3FFFFF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             play = 1'b0;
  logic             stop = 1'b0;
  logic             pause = 1'b0;
  logic             loop_en = 1'b0;
  logic [AddrW-1:0] rom_addr;
  logic [7:0]       rom_data;
  logic [21:0]      note_div;
  logic             mute;
  logic             busy;
  logic             song_done;

  logic [7:0] rom [16];

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle, 1 fetch, 2 load, 3 sounding; m_left = cycles left in note.
  int          m_mode = 0;
  int          m_ptr = 0;
  int          m_left = 0;
  logic [21:0] m_div = DivRest;
  logic        m_mute = 1'b1;
  logic        m_paused = 1'b0;
  logic        m_done = 1'b0;

  int cnt_c4, cnt_e4, cnt_c4_muted, cnt_done, cnt_sound, cnt_busy;

  melody_sequencer #(
    .BEAT_DIV (BeatDiv),
    .ADDR_W   (AddrW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .play      (play),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note_div  (note_div),
    .mute      (mute),
    .busy      (busy),
    .song_done (song_done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] div_of(input logic [3:0] code);
    case (code)
      4'd1:    return 22'd191109;
      4'd2:    return 22'd170263;
      4'd3:    return 22'd151684;
      4'd4:    return 22'd143171;
      4'd5:    return 22'd127550;
      4'd6:    return 22'd113635;
      4'd7:    return 22'd101238;
      4'd8:    return 22'd95556;
      default: return DivRest;
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] e;
    m_done = 1'b0;
    if (rst) begin
      m_mode = 0; m_ptr = 0; m_left = 0; m_div = DivRest; m_mute = 1'b1; m_paused = 1'b0;
    end else if (stop) begin
      m_mode = 0; m_ptr = 0; m_div = DivRest; m_mute = 1'b1; m_paused = 1'b0;
    end else begin
      case (m_mode)
        0: if (play) begin m_mode = 1; m_ptr = 0; end
        1: m_mode = 2;
        2: begin
          e = rom[m_ptr];
          if (e[3:0] == 4'd0) begin
            m_ptr = 0;
            if (loop_en) m_mode = 1;
            else begin
              m_mode = 0; m_done = 1'b1; m_mute = 1'b1; m_div = DivRest;
            end
          end else begin
            m_div  = div_of(e[7:4]);
            m_mute = (e[7:4] == 4'd0) || (e[7:4] > 4'd8);
            m_left = int'(e[3:0]) * BeatDiv;
            m_mode = 3;
          end
        end
        default: begin
          m_paused = pause;
          if (!pause) begin
            m_left--;
            if (m_left == 0) begin
              m_ptr  = (m_ptr + 1) % 16;
              m_mode = 1;
            end
          end
        end
      endcase
    end
  endtask

  // One clock: advance the model with the inputs the DUT sees, then compare.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("note_div", note_div, m_div);
    check_eq("mute", mute, m_mute | m_paused);
    check_eq("busy", busy, m_mode != 0);
    check_eq("song_done", song_done, m_done);
    if (m_mode == 1) check_eq("rom_addr", rom_addr, m_ptr[3:0]);
    if (note_div == 22'd191109) cnt_c4++;
    if (note_div == 22'd191109 && mute) cnt_c4_muted++;
    if (note_div == 22'd151684) cnt_e4++;
    if (song_done) cnt_done++;
    if (!mute) cnt_sound++;
    if (busy) cnt_busy++;
  endtask

  task automatic clear_counts();
    cnt_c4 = 0; cnt_e4 = 0; cnt_c4_muted = 0; cnt_done = 0; cnt_sound = 0; cnt_busy = 0;
  endtask

  task automatic set_song(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = e0; rom[1] = e1; rom[2] = e2;
  endtask

  task automatic start_song(input int cycles);
    clear_counts();
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (cycles - 1) tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rst = 1'b1;
    repeat (2) tick();
    check_eq("reset_div", note_div, DivRest);
    check_eq("reset_mute", mute, 1'b1);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_addr", rom_addr, 0);
    rst = 1'b0;
    tick();

    // Basic song ending with song_done.
    set_song(8'h12, 8'h31, 8'h00);
    start_song(30);
    check_eq("t1_c4_cycles", cnt_c4, 10);
    check_eq("t1_e4_cycles", cnt_e4, 6);
    check_eq("t1_done_pulses", cnt_done, 1);
    check_eq("t1_idle_busy", busy, 1'b0);
    check_eq("t1_idle_mute", mute, 1'b1);

    // Looping: two full passes, no song_done.
    loop_en = 1'b1;
    start_song(38);
    check_eq("t2_c4_cycles", cnt_c4, 20);
    check_eq("t2_e4_cycles", cnt_e4, 16);
    check_eq("t2_no_done", cnt_done, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    loop_en = 1'b0;
    tick();

    // Rests: code 0 and code F are silent for two beats.
    set_song(8'h02, 8'h00, 8'h00);
    start_song(20);
    check_eq("t3_rest_sound", cnt_sound, 0);
    check_eq("t3_rest_busy", cnt_busy, 12);
    check_eq("t3_rest_done", cnt_done, 1);
    set_song(8'hF2, 8'h00, 8'h00);
    start_song(20);
    check_eq("t3_restf_sound", cnt_sound, 0);
    check_eq("t3_restf_busy", cnt_busy, 12);

    // Pause held 7 cycles stretches the note by exactly 7 cycles.
    set_song(8'h12, 8'h00, 8'h00);
    start_song(20);
    check_eq("t4_ref_len", cnt_c4, 10);
    start_song(5);
    pause = 1'b1;
    repeat (7) tick();
    pause = 1'b0;
    repeat (25) tick();
    check_eq("t4_paused_len", cnt_c4, 17);
    check_eq("t4_muted_cycles", cnt_c4_muted, 7);

    // stop together with play mid-song, then a fresh play from entry 0.
    set_song(8'h12, 8'h31, 8'h00);
    start_song(6);
    stop = 1'b1; play = 1'b1;
    tick();
    stop = 1'b0; play = 1'b0;
    check_eq("t5_stop_busy", busy, 1'b0);
    check_eq("t5_stop_mute", mute, 1'b1);
    check_eq("t5_stop_div", note_div, DivRest);
    check_eq("t5_stop_addr", rom_addr, 0);
    repeat (2) tick();
    start_song(1);
    check_eq("t5_restart_addr", rom_addr, 0);
    check_eq("t5_restart_busy", busy, 1'b1);
    repeat (30) tick();

    // Full ROM without end marker wraps the address; then reset mid-note.
    for (int i = 0; i < 16; i++) rom[i] = {4'($urandom_range(1, 8)), 4'd1};
    start_song(110);
    rst = 1'b1;
    tick();
    check_eq("t6_rst_div", note_div, DivRest);
    check_eq("t6_rst_mute", mute, 1'b1);
    check_eq("t6_rst_busy", busy, 1'b0);
    check_eq("t6_rst_done", song_done, 1'b0);
    check_eq("t6_rst_addr", rom_addr, 0);
    rst = 1'b0;
    tick();

    // Random songs and random control traffic.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 16; i++) begin
        rom[i][7:4] = 4'($urandom_range(0, 15));
        rom[i][3:0] = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
      end
      loop_en = 1'($urandom_range(0, 1));
      start_song(1);
      for (int n = $urandom_range(30, 150); n > 0; n--) begin
        if ($urandom_range(0, 7) == 0) pause = ~pause;
        stop = ($urandom_range(0, 99) == 0);
        play = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 63) == 0) loop_en = ~loop_en;
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
      play = 1'b0; rst = 1'b0; pause = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
